// File: rtl/case_scan_sequencer.sv
// Priority case-item scanner: one item per cycle, first match wins, result held until consumed.
// Item 0 is the per-request key; items 1..NITEMS-1 come from a small writable table.
module case_scan_sequencer #(
  parameter int W = 4,
  parameter int NITEMS = 4,
  parameter int ANS_W = 4,
  parameter logic [ANS_W-1:0] DEFAULT_ANS = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_sel,
  input  logic [W-1:0]     in_key,
  input  logic [ANS_W-1:0] in_key_ans,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_idx,
  input  logic [W-1:0]     cfg_val,
  input  logic [ANS_W-1:0] cfg_ans,
  output logic             cfg_ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ans,
  output logic             out_hit,
  output logic [3:0]       out_idx,
  output logic [W-1:0]     out_sel_next
);

  localparam logic [4:0] LAST = 5'(NITEMS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]     sel_q;
  logic [W-1:0]     key_q;
  logic [W-1:0]     sel_next_q;
  logic [ANS_W-1:0] key_ans_q;
  logic [3:0]       ptr;

  // Sized to the full 4-bit index space; entries at or above NITEMS stay invalid forever.
  logic [W-1:0]     tbl_val [16];
  logic [ANS_W-1:0] tbl_ans [16];
  logic [15:0]      tbl_vld;

  logic             accept;
  logic             cfg_ok;
  logic             at_last;
  logic             item_hit;
  logic [ANS_W-1:0] item_ans;

  assign cfg_ok    = cfg_we && (state == IDLE) && (cfg_idx != 4'd0) && ({1'b0, cfg_idx} <= LAST);
  assign at_last   = ({1'b0, ptr} == LAST);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Only the captured pre-increment selector is ever compared.
  always_comb begin
    item_hit = 1'b0;
    item_ans = key_ans_q;
    if (ptr == 4'd0) begin
      item_hit = (key_q == sel_q);
    end else begin
      item_hit = tbl_vld[ptr] && (tbl_val[ptr] == sel_q);
      item_ans = tbl_ans[ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (item_hit || at_last) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q        <= '0;
      key_q        <= '0;
      key_ans_q    <= '0;
      sel_next_q   <= '0;
      ptr          <= '0;
      cfg_ack      <= 1'b0;
      out_ans      <= '0;
      out_hit      <= 1'b0;
      out_idx      <= '0;
      out_sel_next <= '0;
      tbl_vld      <= '0;
      for (int i = 0; i < 16; i++) begin
        tbl_val[i] <= '0;
        tbl_ans[i] <= '0;
      end
    end else begin
      cfg_ack <= cfg_ok;
      // A same-cycle write lands before the first SCAN compare, so the new request sees it.
      if (cfg_ok) begin
        tbl_val[cfg_idx] <= cfg_val;
        tbl_ans[cfg_idx] <= cfg_ans;
        tbl_vld[cfg_idx] <= 1'b1;
      end
      if (accept) begin
        sel_q      <= in_sel;
        key_q      <= in_key;
        key_ans_q  <= in_key_ans;
        sel_next_q <= in_sel + W'(1);
        ptr        <= '0;
      end
      if (state == SCAN) begin
        if (item_hit) begin
          out_ans      <= 32'(item_ans);
          out_hit      <= 1'b1;
          out_idx      <= ptr;
          out_sel_next <= sel_next_q;
        end else if (at_last) begin
          out_ans      <= 32'(DEFAULT_ANS);
          out_hit      <= 1'b0;
          out_idx      <= '0;
          out_sel_next <= sel_next_q;
        end else begin
          ptr <= ptr + 4'd1;
        end
      end
    end
  end

endmodule
